// File: rtl/mod3_pkg.sv
// Shared definitions for the mod-3 serial transmitter: FSM state encoding,
// pad length and the single-bit residue step (r' = (2r + b) mod 3).
package mod3_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Number of pad bits appended when padding is enabled.
    localparam int PAD_BITS = 2;

    // One step of the MSB-first residue recurrence. r = 3 never occurs.
    function automatic logic [1:0] mod3_step_f(input logic [1:0] r, input logic b);
        logic [1:0] r_next;
        case ({r, b})
            3'b000:  r_next = 2'd0;
            3'b001:  r_next = 2'd1;
            3'b010:  r_next = 2'd2;
            3'b011:  r_next = 2'd0;
            3'b100:  r_next = 2'd1;
            3'b101:  r_next = 2'd2;
            default: r_next = 2'd0;
        endcase
        return r_next;
    endfunction

endpackage

// File: rtl/mod3_step.sv
// Per-bit residue update: r_next = (2*r + b) mod 3.
module mod3_step (
    input  logic [1:0] r,
    input  logic       b,
    output logic [1:0] r_next
);
    import mod3_pkg::*;

    assign r_next = mod3_step_f(r, b);

endmodule

// File: rtl/mod3_stream_tx.sv
// Parallel-to-serial transmitter that emits each accepted word MSB first,
// framed by start/stop strobes, and reports the mod-3 residue of the bits
// sent. Define MOD3_TX_PAD_EN to append two pad bits that force the
// reported residue to zero.
module mod3_stream_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             start,
    output logic             stop,
    output logic             data,
    output logic             busy,
    output logic [1:0]       residue,
    output logic             residue_valid
);
    import mod3_pkg::*;

`ifdef MOD3_TX_PAD_EN
    localparam int FRAME_LEN = WIDTH + PAD_BITS;
`else
    localparam int FRAME_LEN = WIDTH;
`endif
    // Holds FRAME_LEN-1 down to 0 without wrapping.
    localparam int CNT_W = $clog2(WIDTH + 3);

    state_t               state, state_next;
    logic                 accept;
    logic                 last_bit;
    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-1:0] sreg;
    logic [CNT_W-1:0]     cnt;
    logic [1:0]           run_r;
    logic [1:0]           step_r;
    logic                 step_b;
    logic [1:0]           step_next;

    assign in_ready = ~rst & (state != ST_SHIFT);
    assign accept   = in_valid & in_ready;
    assign last_bit = (state == ST_SHIFT) && (cnt == '0);

    // Build the frame to transmit from the offered word (plus pad if enabled).
`ifdef MOD3_TX_PAD_EN
    logic [1:0] word_res;
    logic [1:0] pad;
    always_comb begin
        word_res = 2'd0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            word_res = mod3_step_f(word_res, in_data[i]);
        end
        pad   = (word_res == 2'd0) ? 2'd0 : (2'd3 - word_res);
        frame = {in_data, pad};
    end
`else
    always_comb begin
        frame = in_data;
    end
`endif

    // Residue step input: restart from 0 on accept, otherwise continue the frame.
    always_comb begin
        step_r = (state == ST_SHIFT) ? run_r : 2'd0;
        step_b = (state == ST_SHIFT) ? sreg[FRAME_LEN-1] : frame[FRAME_LEN-1];
    end

    mod3_step u_step (
        .r      (step_r),
        .b      (step_b),
        .r_next (step_next)
    );

    // State register.
    // NOTE: sequential blocks use non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state decode.
    // NOTE: the default assignment first keeps every path assigned, so no
    // latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_SHIFT;
            ST_SHIFT: if (cnt == '0) state_next = ST_GAP;
            ST_GAP:   state_next = accept ? ST_SHIFT : ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Frame shift register; load on accept, shift one bit per SHIFT cycle.
    // NOTE: pure data storage needs no reset; it is always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            sreg <= frame << 1;
        end else if (state == ST_SHIFT) begin
            sreg <= sreg << 1;
        end
    end

    // Registered serial outputs, bit counter, running and reported residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            start         <= 1'b0;
            stop          <= 1'b0;
            data          <= 1'b0;
            busy          <= 1'b0;
            residue       <= 2'd0;
            residue_valid <= 1'b0;
            run_r         <= 2'd0;
            cnt           <= '0;
        end else begin
            start         <= 1'b0;
            stop          <= 1'b0;
            data          <= 1'b0;
            busy          <= 1'b0;
            residue_valid <= 1'b0;
            if (accept) begin
                // First bit goes out on the cycle after the accept edge.
                start <= 1'b1;
                busy  <= 1'b1;
                data  <= frame[FRAME_LEN-1];
                run_r <= step_next;
                cnt   <= CNT_W'(FRAME_LEN - 1);
            end else if ((state == ST_SHIFT) && (cnt != '0)) begin
                busy  <= 1'b1;
                data  <= sreg[FRAME_LEN-1];
                stop  <= (cnt == CNT_W'(1));
                run_r <= step_next;
                cnt   <= cnt - CNT_W'(1);
            end else if (last_bit) begin
                // Last bit was on the wire this cycle; report the residue in GAP.
                residue       <= run_r;
                residue_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod3_stream_tx.sv
// Directed self-checking bench for mod3_stream_tx (WIDTH=8). Expected frames
// and residues are hand-computed constants for both the plain and the
// MOD3_TX_PAD_EN build.
module tb_mod3_stream_tx;

`ifdef MOD3_TX_PAD_EN
    localparam int FL = 10;
`else
    localparam int FL = 8;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       start;
    logic       stop;
    logic       data;
    logic       busy;
    logic [1:0] residue;
    logic       residue_valid;

    int checks   = 0;
    int failures = 0;

    mod3_stream_tx #(.WIDTH(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .start         (start),
        .stop          (stop),
        .data          (data),
        .busy          (busy),
        .residue       (residue),
        .residue_valid (residue_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called on the first bit cycle (T+1). Checks every bit cycle and the
    // residue pulse at T+L+1; returns while still in that GAP cycle.
    task automatic check_frame(input string tag, input logic [9:0] bits,
                               input logic [1:0] res, input bit scramble);
        for (int i = 0; i < FL; i++) begin
            chk({tag, "_bit"}, {28'd0, start, stop, busy, data},
                {28'd0, (i == 0), (i == FL - 1), 1'b1, bits[FL-1-i]});
            chk({tag, "_rdy"}, {31'd0, in_ready}, 32'd0);
            chk({tag, "_rv"}, {31'd0, residue_valid}, 32'd0);
            if (scramble) in_data = 8'($urandom);
            step();
        end
        chk({tag, "_gap"}, {28'd0, start, stop, busy, data}, 32'd0);
        chk({tag, "_rvp"}, {31'd0, residue_valid}, 32'd1);
        chk({tag, "_res"}, {30'd0, residue}, {30'd0, res});
        chk({tag, "_gaprdy"}, {31'd0, in_ready}, 32'd1);
    endtask

    // Offer a word in an idle cycle and step to the first bit cycle.
    task automatic send(input logic [7:0] w);
        in_valid = 1'b1;
        in_data  = w;
        chk("accept_rdy", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // One cycle after the pulse: back in IDLE, pulse gone, residue held.
    task automatic check_idle_hold(input string tag, input logic [1:0] res);
        step();
        chk({tag, "_idle"}, {27'd0, start, stop, busy, data, residue_valid}, 32'd0);
        chk({tag, "_hold"}, {30'd0, residue}, {30'd0, res});
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        chk("rst_outs", {27'd0, start, stop, busy, data, residue_valid}, 32'd0);
        chk("rst_res", {30'd0, residue}, 32'd0);
        chk("rst_rdy", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_rdy", {31'd0, in_ready}, 32'd1);
        step();

        // 0x06: residue 0 either way; pad is 00.
        send(8'h06);
`ifdef MOD3_TX_PAD_EN
        check_frame("w06", 10'b0000011000, 2'd0, 1'b1);
        check_idle_hold("w06", 2'd0);
`else
        check_frame("w06", 10'b0000000110, 2'd0, 1'b1);
        check_idle_hold("w06", 2'd0);
`endif

        // 0x07: residue 1 plain; pad 10 forces 0.
        send(8'h07);
`ifdef MOD3_TX_PAD_EN
        check_frame("w07", 10'b0000011110, 2'd0, 1'b1);
        check_idle_hold("w07", 2'd0);
`else
        check_frame("w07", 10'b0000000111, 2'd1, 1'b1);
        check_idle_hold("w07", 2'd1);
`endif

        // 0x80: residue 2 plain; pad 01 forces 0.
        send(8'h80);
`ifdef MOD3_TX_PAD_EN
        check_frame("w80", 10'b1000000001, 2'd0, 1'b1);
        check_idle_hold("w80", 2'd0);
`else
        check_frame("w80", 10'b0010000000, 2'd2, 1'b1);
        check_idle_hold("w80", 2'd2);
`endif

        // Back-to-back: in_valid stays high; second word accepted in GAP.
        in_valid = 1'b1;
        in_data  = 8'h01;
        step();
        in_data  = 8'hFF;
`ifdef MOD3_TX_PAD_EN
        check_frame("b2b_01", 10'b0000000110, 2'd0, 1'b0);
`else
        check_frame("b2b_01", 10'b0000000001, 2'd1, 1'b0);
`endif
        step();
        in_valid = 1'b0;
`ifdef MOD3_TX_PAD_EN
        check_frame("b2b_ff", 10'b1111111100, 2'd0, 1'b1);
`else
        check_frame("b2b_ff", 10'b0011111111, 2'd0, 1'b1);
`endif
        check_idle_hold("b2b_ff", 2'd0);

        // Reset mid-frame on 0xA5 (bits 1,0,1,0,...), with in_valid high in the rst cycle.
        send(8'hA5);
        chk("a5_b1", {28'd0, start, stop, busy, data}, 32'b1011);
        step();
        chk("a5_b2", {28'd0, start, stop, busy, data}, 32'b0010);
        step();
        chk("a5_b3", {28'd0, start, stop, busy, data}, 32'b0011);
        step();
        chk("a5_b4", {28'd0, start, stop, busy, data}, 32'b0010);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h55;
        #1;
        chk("a5_rst_rdy", {31'd0, in_ready}, 32'd0);
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("a5_cut_outs", {27'd0, start, stop, busy, data, residue_valid}, 32'd0);
        chk("a5_cut_res", {30'd0, residue}, 32'd0);
        for (int i = 0; i < FL + 2; i++) begin
            step();
            chk("a5_quiet", {27'd0, start, stop, busy, data, residue_valid}, 32'd0);
        end

        // Clean frame after reset: 0x03, residue 0, pad 00.
        send(8'h03);
`ifdef MOD3_TX_PAD_EN
        check_frame("w03", 10'b0000001100, 2'd0, 1'b1);
`else
        check_frame("w03", 10'b0000000011, 2'd0, 1'b1);
`endif
        check_idle_hold("w03", 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
